// File: rtl/fpga_pkg.sv
// Shared constants and FSM state encoding for the result memory read-back path.
package fpga_pkg;

  // Read port geometry of the result memory inside top
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 12;
  localparam int N_WORDS = 512;
  // Cycles from a stable address to valid data at top's result output
  localparam int RD_LAT  = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/result_readout.sv
// Drains top's result memory word by word onto a valid/ready stream once all
// four cores have signalled completion, then waits for the flags to drop
// before it can be armed again.
module result_readout #(
  parameter int ADDR_W  = fpga_pkg::ADDR_W,
  parameter int DATA_W  = fpga_pkg::DATA_W,
  parameter int N_WORDS = fpga_pkg::N_WORDS,
  parameter int RD_LAT  = fpga_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        end_process,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  import fpga_pkg::*;

  // The wait counter only has to hold RD_LAT-1
  localparam int                 CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_WORDS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [DATA_W-1:0]   r_out_data;
  logic [DATA_W-1:0]   w_out_data_next;
  logic                r_out_valid;
  logic                w_out_valid_next;
  logic                r_done;
  logic                w_done_next;

  logic                w_all_done;
  logic                w_handshake;
  logic                w_at_last;

  assign w_all_done  = (end_process == 4'b1111);
  assign w_handshake = r_out_valid && out_ready;
  assign w_at_last   = (r_addr == LAST_ADDR);

  // State and datapath registers; reset may arrive mid-drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_addr      <= w_addr_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_done      <= w_done_next;
    end
  end

  // Next-state and next-datapath logic; everything holds unless a branch says otherwise
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_addr_next      = r_addr;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    w_done_next      = r_done;

    case (r_state)
      IDLE: begin
        w_addr_next = '0;
        if (w_all_done) begin
          w_state_next = READ;
          w_cnt_next   = CNT_LOAD;
        end
      end

      // Address is already stable; wait out the memory latency, then capture
      READ: begin
        if (r_cnt == '0) begin
          w_out_data_next  = result;
          w_out_valid_next = 1'b1;
          w_state_next     = HOLD;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

      // Word presented; nothing moves until the consumer takes it
      HOLD: begin
        if (w_handshake) begin
          if (w_at_last) begin
            w_out_valid_next = 1'b0;
            w_done_next      = 1'b1;
            w_state_next     = DONE;
          end else begin
            w_out_valid_next = 1'b0;
            w_addr_next      = r_addr + ADDR_W'(1);
            w_cnt_next       = CNT_LOAD;
            w_state_next     = READ;
          end
        end
      end

      // Stay parked until the cores clear their flags, so one computation drains once
      DONE: begin
        w_addr_next = LAST_ADDR;
        if (!w_all_done) begin
          w_done_next  = 1'b0;
          w_addr_next  = '0;
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign addr     = r_addr;
  assign out_data = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last = r_out_valid && w_at_last;
  assign busy     = (r_state == READ) || (r_state == HOLD);
  assign done     = r_done;

endmodule
